// File: rtl/yiwei_ctrl.sv
// Command sequencer for a W-bit universal shift register: accepts one command over
// valid/ready, drives sel/data/Rin/Lin for the required cycles, and pulses done with the result.
module yiwei_ctrl #(
   parameter int W  = 4,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [CW-1:0] cmd_cnt,
   input  logic [W-1:0]  cmd_data,
   input  logic          ser_in,
   input  logic [W-1:0]  qin,
   output logic [1:0]    sel,
   output logic [W-1:0]  data,
   output logic          Rin,
   output logic          Lin,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  result
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   localparam logic [2:0] OP_NOP = 3'b000, OP_LOAD = 3'b001, OP_SHR = 3'b010,
                          OP_SHL = 3'b011, OP_ROR = 3'b100, OP_ROL = 3'b101,
                          OP_ASR = 3'b110, OP_CLR = 3'b111;

   state_t        state_q, state_d;
   logic [2:0]    op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  ld_q, ld_d;
   logic [1:0]    sel_q;
   logic [W-1:0]  dat_q;
   logic          busy_q, done_q, rdy_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      ld_d    = ld_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            op_d  = cmd_op;
            cnt_d = cmd_cnt;
            ld_d  = (cmd_op == OP_LOAD) ? cmd_data : '0;
            case (cmd_op)
               OP_NOP:          state_d = DONE;
               OP_LOAD, OP_CLR: state_d = LOAD;
               default:         state_d = (cmd_cnt == '0) ? DONE : SHIFT;
            endcase
         end
         LOAD:  state_d = DONE;
         SHIFT: begin
            // Counter stops at 1, so it can never wrap.
            if (cnt_q == CW'(1)) state_d = DONE;
            else                 cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they track state_q exactly.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         cnt_q   <= '0;
         ld_q    <= '0;
         sel_q   <= 2'b00;
         dat_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         ld_q    <= ld_d;
         case (state_d)
            LOAD:    sel_q <= 2'b11;
            SHIFT:   sel_q <= op_d[0] ? 2'b10 : 2'b01;
            default: sel_q <= 2'b00;
         endcase
         dat_q  <= (state_d == LOAD) ? ld_d : '0;
         busy_q <= (state_d != IDLE);
         done_q <= (state_d == DONE);
         rdy_q  <= (state_d == IDLE);
      end
   end

   always_comb begin
      Rin = 1'b0;
      Lin = 1'b0;
      if (state_q == SHIFT) begin
         case (op_q)
            OP_SHR:  Rin = ser_in;
            OP_ROR:  Rin = qin[0];
            OP_ASR:  Rin = qin[W-1];
            OP_SHL:  Lin = ser_in;
            OP_ROL:  Lin = qin[W-1];
            default: ;
         endcase
      end
   end

   assign sel       = sel_q;
   assign data      = dat_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cmd_ready = rdy_q;
   assign result    = done_q ? qin : '0;

endmodule

// File: tb/tb_yiwei_ctrl.sv
// Directed bench for yiwei_ctrl with a behavioural shift register on sel/data/Rin/Lin
// and a scoreboard of expected result/latency per command.
module tb_yiwei_ctrl;

   logic       clk = 1'b0;
   logic       clr, cmd_valid, cmd_ready, ser_in;
   logic [2:0] cmd_op, cmd_cnt;
   logic [3:0] cmd_data, qin, data, result;
   logic [1:0] sel;
   logic       Rin, Lin, busy, done;

   logic [3:0] q = 4'b0000;
   int         checks = 0, errors = 0, accepts = 0;

   typedef struct {logic [3:0] res; int lat;} exp_t;
   exp_t sb[$];

   yiwei_ctrl #(.W(4), .CW(3)) dut (
      .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .ser_in(ser_in),
      .qin(qin), .sel(sel), .data(data), .Rin(Rin), .Lin(Lin), .busy(busy),
      .done(done), .result(result)
   );

   always #5 clk = ~clk;
   assign qin = q;

   // The shift register the controller steers.
   always @(posedge clk) begin
      case (sel)
         2'b01:   q <= {Rin, q[3:1]};
         2'b10:   q <= {q[2:0], Lin};
         2'b11:   q <= data;
         default: q <= q;
      endcase
      if (cmd_valid && cmd_ready && !clr) accepts <= accepts + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref_op(input logic [2:0] op, input int cnt,
                                         input logic [3:0] d, input logic s, input logic [3:0] q0);
      logic [3:0] r;
      r = q0;
      case (op)
         3'd1: r = d;
         3'd7: r = 4'b0000;
         3'd0: r = q0;
         default: for (int i = 0; i < cnt; i++) begin
            case (op)
               3'd2: r = {s, r[3:1]};
               3'd3: r = {r[2:0], s};
               3'd4: r = {r[0], r[3:1]};
               3'd5: r = {r[2:0], r[3]};
               default: r = {r[3], r[3:1]};
            endcase
         end
      endcase
      return r;
   endfunction

   task automatic do_cmd(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] d,
                         input logic s, input bit hold, input string tag);
      exp_t e;
      int   k, acc0;
      logic [1:0] esel;
      k = 0;
      while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
      chk({tag, "_ready"}, cmd_ready, 1);
      e.res = ref_op(op, cnt, d, s, q);
      e.lat = (op == 3'd0) ? 1 : (op == 3'd1 || op == 3'd7) ? 2 : (cnt == 0) ? 1 : cnt + 1;
      sb.push_back(e);
      esel = (op == 3'd1 || op == 3'd7) ? 2'b11 : op[0] ? 2'b10 : 2'b01;
      acc0 = accepts;
      cmd_op = op; cmd_cnt = cnt; cmd_data = d; ser_in = s; cmd_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
      @(negedge clk); k = 1;
      while (!done && k <= 20) begin
         chk({tag, "_sel"}, sel, esel);
         chk({tag, "_busy"}, busy, 1);
         if (esel == 2'b11) chk({tag, "_data"}, data, (op == 3'd7) ? 4'b0 : d);
         else if (esel == 2'b01) begin
            chk({tag, "_rin"}, Rin, (op == 3'd2) ? s : (op == 3'd4) ? q[0] : q[3]);
            chk({tag, "_lin"}, Lin, 0);
         end else begin
            chk({tag, "_lin"}, Lin, (op == 3'd3) ? s : q[3]);
            chk({tag, "_rin"}, Rin, 0);
         end
         @(negedge clk); k++;
      end
      cmd_valid = 1'b0;
      if (sb.size() > 0) e = sb.pop_front();
      chk({tag, "_latency"}, k, e.lat);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_sel_done"}, sel, 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_accepts"}, accepts - acc0, 1);
   endtask

   initial begin
      int dn;
      clr = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_cnt = '0; cmd_data = '0; ser_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sel", sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_result", result, 0);
      chk("rst_data", data, 0);
      chk("rst_fill", {Rin, Lin}, 0);
      @(negedge clk); clr = 1'b0;
      @(negedge clk);

      do_cmd(3'd1, 3'd0, 4'b1011, 1'b0, 0, "load1011");
      do_cmd(3'd4, 3'd1, 4'b0000, 1'b0, 0, "ror1");
      do_cmd(3'd1, 3'd0, 4'b1011, 1'b0, 0, "load1011b");
      do_cmd(3'd5, 3'd4, 4'b0000, 1'b0, 0, "rol4");
      do_cmd(3'd1, 3'd0, 4'b1000, 1'b0, 0, "load1000");
      do_cmd(3'd6, 3'd3, 4'b0000, 1'b0, 0, "asr3");
      do_cmd(3'd7, 3'd5, 4'b1111, 1'b1, 0, "clear");
      do_cmd(3'd3, 3'd2, 4'b0000, 1'b1, 0, "shl2");
      do_cmd(3'd2, 3'd0, 4'b0000, 1'b1, 0, "shr0");
      do_cmd(3'd0, 3'd3, 4'b0101, 1'b0, 0, "nop");
      do_cmd(3'd2, 3'd7, 4'b0000, 1'b0, 1, "shr7_hold");
      do_cmd(3'd1, 3'd0, 4'b1001, 1'b0, 0, "load1001");
      do_cmd(3'd2, 3'd7, 4'b0000, 1'b1, 0, "shr7_fill");
      chk("final_q", q, 4'b1111);

      // Abort a cnt=5 shift in its 2nd SHIFT cycle.
      cmd_op = 3'd2; cmd_cnt = 3'd5; ser_in = 1'b1; cmd_valid = 1'b1;
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_pre", busy, 1);
      clr = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sel", sel, 0);
      chk("abort_ready", cmd_ready, 1);
      @(negedge clk); clr = 1'b0;
      dn = 0;
      repeat (8) begin @(negedge clk); if (done) dn++; end
      chk("abort_no_done", dn, 0);

      do_cmd(3'd1, 3'd0, 4'b0110, 1'b0, 0, "load_after_abort");
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
